// File: rtl/i2c_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_seq_pkg                                                  |
// | Description : Shared state encoding, table markers and entry field layout  |
// |               for the I2C init sequencer.                                  |
// |               Optional: I2C_INIT_SEQUENCER_READBACK_EN adds verify states. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package i2c_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE             = 4'd0,
        ST_FETCH            = 4'd1,
        ST_DECODE           = 4'd2,
        ST_ISSUE            = 4'd3,
        ST_WAIT_BUSY        = 4'd4,
        ST_WAIT_DONE        = 4'd5,
        ST_CHECK            = 4'd6,
        ST_NEXT             = 4'd7,
        ST_DELAY            = 4'd8,
        ST_DONE             = 4'd9,
`ifdef I2C_INIT_SEQUENCER_READBACK_EN
        ST_ERROR            = 4'd10,
        ST_VERIFY_ISSUE     = 4'd11,
        ST_VERIFY_WAIT_BUSY = 4'd12,
        ST_VERIFY_WAIT_DONE = 4'd13,
        ST_VERIFY_CHECK     = 4'd14
`else
        ST_ERROR            = 4'd10
`endif
    } seq_state_e;

    localparam logic [7:0] SEQ_END_MARKER   = 8'hFF;
    localparam logic [7:0] SEQ_DELAY_MARKER = 8'hFE;

    // Table entry layout: register byte in the upper half, data byte in the lower
    localparam int unsigned ENTRY_REG_MSB  = 15;
    localparam int unsigned ENTRY_REG_LSB  = 8;
    localparam int unsigned ENTRY_DATA_MSB = 7;
    localparam int unsigned ENTRY_DATA_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/i2c_seq_delay_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_seq_delay_timer                                          |
// | Description : Prescaler of DELAY_UNIT_CYCLES plus 8-bit unit down-counter; |
// |               expired is high whenever no units remain.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module i2c_seq_delay_timer #(
    parameter int unsigned DELAY_UNIT_CYCLES = 12000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] units,
    output logic       expired
);

    localparam int unsigned   c_presc_w    = (DELAY_UNIT_CYCLES > 1) ? $clog2(DELAY_UNIT_CYCLES) : 1;
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(DELAY_UNIT_CYCLES - 1);

    logic [c_presc_w-1:0] presc_q, presc_d;
    logic [7:0]           units_q, units_d;

    always_comb begin
        presc_d = presc_q;
        units_d = units_q;
        if (load) begin
            presc_d = '0;
            units_d = units;
        end else if (units_q != 8'd0) begin
            if (presc_q == c_presc_last) begin
                presc_d = '0;
                units_d = units_q - 8'd1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            units_q <= 8'd0;
        end else begin
            presc_q <= presc_d;
            units_q <= units_d;
        end
    end

    assign expired = (units_q == 8'd0);

endmodule
`default_nettype wire

// File: rtl/i2c_init_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_init_sequencer                                           |
// | Description : Walks a register-write table through a single-byte I2C       |
// |               master with delays, end marker, NACK retry and status flags. |
// |               Optional: I2C_INIT_SEQUENCER_READBACK_EN verifies each write.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module i2c_init_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int unsigned TABLE_DEPTH       = 64,
    parameter logic [6:0]  DEVICE_ADDRESS    = 7'h21,
    parameter int unsigned MAX_RETRIES       = 3,
    parameter int unsigned DELAY_UNIT_CYCLES = 12000,
    localparam int unsigned IDXW             = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    output logic [IDXW-1:0] tableIndex,
    input  logic [15:0]     tableEntry,
    output logic            i2cStartWrite,
    output logic            i2cStartRead,
    output logic [6:0]      i2cAddress,
    output logic [7:0]      i2cRegister,
    output logic [7:0]      i2cData,
    input  logic            i2cBusy,
    input  logic            i2cAckError,
    input  logic [7:0]      i2cDataOut,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [IDXW-1:0] failedIndex
);

    localparam int unsigned     c_retry_w       = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [c_retry_w-1:0] c_max_retries = c_retry_w'(MAX_RETRIES);
    localparam logic [IDXW-1:0] c_last_index    = IDXW'(TABLE_DEPTH - 1);

    seq_state_e           state_q, state_d;
    logic [IDXW-1:0]      index_q, index_d;
    logic [c_retry_w-1:0] retry_q, retry_d;
    logic                 last_q, last_d;
    logic [7:0]           reg_q, reg_d;
    logic [7:0]           data_q, data_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic [IDXW-1:0]      failed_q, failed_d;

    logic                 w_timer_load;
    logic                 w_timer_expired;
    logic                 w_at_last;
    logic [IDXW-1:0]      w_index_inc;

    // The index saturates at the last entry; last_q remembers that so NEXT can stop.
    assign w_at_last   = (index_q == c_last_index);
    assign w_index_inc = w_at_last ? index_q : index_q + 1'b1;

    i2c_seq_delay_timer #(
        .DELAY_UNIT_CYCLES(DELAY_UNIT_CYCLES)
    ) u_delay_timer (
        .clk    (clock),
        .rst    (reset),
        .load   (w_timer_load),
        .units  (tableEntry[ENTRY_DATA_MSB:ENTRY_DATA_LSB]),
        .expired(w_timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        retry_d      = retry_q;
        last_d       = last_q;
        reg_d        = reg_q;
        data_d       = data_q;
        done_d       = done_q;
        error_d      = error_q;
        failed_d     = failed_q;
        w_timer_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    index_d  = '0;
                    retry_d  = '0;
                    last_d   = 1'b0;
                    done_d   = 1'b0;
                    error_d  = 1'b0;
                    failed_d = '0;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                reg_d  = tableEntry[ENTRY_REG_MSB:ENTRY_REG_LSB];
                data_d = tableEntry[ENTRY_DATA_MSB:ENTRY_DATA_LSB];
                if (tableEntry[ENTRY_REG_MSB:ENTRY_REG_LSB] == SEQ_END_MARKER) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (tableEntry[ENTRY_REG_MSB:ENTRY_REG_LSB] == SEQ_DELAY_MARKER) begin
                    w_timer_load = 1'b1;
                    state_d      = ST_DELAY;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (i2cBusy) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!i2cBusy) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (!i2cAckError) begin
`ifdef I2C_INIT_SEQUENCER_READBACK_EN
                    state_d = ST_VERIFY_ISSUE;
`else
                    index_d = w_index_inc;
                    last_d  = w_at_last;
                    retry_d = '0;
                    state_d = ST_NEXT;
`endif
                end else if (retry_q < c_max_retries) begin
                    retry_d = retry_q + 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    failed_d = index_q;
                    error_d  = 1'b1;
                    state_d  = ST_ERROR;
                end
            end
`ifdef I2C_INIT_SEQUENCER_READBACK_EN
            ST_VERIFY_ISSUE: state_d = ST_VERIFY_WAIT_BUSY;
            ST_VERIFY_WAIT_BUSY: begin
                if (i2cBusy) state_d = ST_VERIFY_WAIT_DONE;
            end
            ST_VERIFY_WAIT_DONE: begin
                if (!i2cBusy) state_d = ST_VERIFY_CHECK;
            end
            ST_VERIFY_CHECK: begin
                if (!i2cAckError && (i2cDataOut == data_q)) begin
                    index_d = w_index_inc;
                    last_d  = w_at_last;
                    retry_d = '0;
                    state_d = ST_NEXT;
                end else if (retry_q < c_max_retries) begin
                    retry_d = retry_q + 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    failed_d = index_q;
                    error_d  = 1'b1;
                    state_d  = ST_ERROR;
                end
            end
`endif
            ST_NEXT: begin
                if (last_q) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DELAY: begin
                if (w_timer_expired) begin
                    index_d = w_index_inc;
                    last_d  = w_at_last;
                    state_d = ST_NEXT;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            index_q  <= '0;
            retry_q  <= '0;
            last_q   <= 1'b0;
            reg_q    <= 8'd0;
            data_q   <= 8'd0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            failed_q <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            retry_q  <= retry_d;
            last_q   <= last_d;
            reg_q    <= reg_d;
            data_q   <= data_d;
            done_q   <= done_d;
            error_q  <= error_d;
            failed_q <= failed_d;
        end
    end

    assign tableIndex    = index_q;
    assign i2cStartWrite = (state_q == ST_ISSUE);
    assign i2cAddress    = DEVICE_ADDRESS;
    assign i2cRegister   = reg_q;
    assign i2cData       = data_q;
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERROR);
    assign done          = done_q;
    assign error         = error_q;
    assign failedIndex   = failed_q;

`ifdef I2C_INIT_SEQUENCER_READBACK_EN
    assign i2cStartRead  = (state_q == ST_VERIFY_ISSUE);
`else
    logic w_unused_read_data;
    assign w_unused_read_data = ^i2cDataOut;
    assign i2cStartRead  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_init_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_i2c_init_sequencer                                        |
// | Description : Scoreboard bench with a table store and I2C master model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_i2c_init_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IDXW  = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [IDXW-1:0] tableIndex;
    logic [15:0]     tableEntry = 16'h0;
    logic            i2cStartWrite, i2cStartRead;
    logic [6:0]      i2cAddress;
    logic [7:0]      i2cRegister, i2cData;
    logic            i2cBusy = 1'b0;
    logic            i2cAckError = 1'b0;
    logic [7:0]      i2cDataOut = 8'h0;
    logic            busy, done, error;
    logic [IDXW-1:0] failedIndex;

    int errors = 0;
    int checks = 0;

    logic [15:0] tbl [DEPTH];
    logic [15:0] exp_q [$];
    logic [15:0] exp_e;
    int          cyc = 0;
    int          wr_count = 0;
    int          first_wr_cyc = 0;
    int          start_cyc = 0;
    int          max_idx = 0;
    bit          wrapped = 1'b0;
    logic [IDXW-1:0] prev_idx = '0;
    logic [7:0]  nack_reg = 8'h00;
    int          nack_left = 0;
    int          rb_bad_left = 0;
    bit          pend = 1'b0;
    bit          pend_rd = 1'b0;
    int          bcnt = 0;

    i2c_init_sequencer #(
        .TABLE_DEPTH      (DEPTH),
        .DEVICE_ADDRESS   (7'h21),
        .MAX_RETRIES      (3),
        .DELAY_UNIT_CYCLES(10)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .tableIndex   (tableIndex),
        .tableEntry   (tableEntry),
        .i2cStartWrite(i2cStartWrite),
        .i2cStartRead (i2cStartRead),
        .i2cAddress   (i2cAddress),
        .i2cRegister  (i2cRegister),
        .i2cData      (i2cData),
        .i2cBusy      (i2cBusy),
        .i2cAckError  (i2cAckError),
        .i2cDataOut   (i2cDataOut),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .failedIndex  (failedIndex)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Table store, master model and write scoreboard, all on the falling edge
    always @(negedge clock) begin
        tableEntry = tbl[tableIndex];
        if (reset) begin
            i2cBusy     = 1'b0;
            i2cAckError = 1'b0;
            pend        = 1'b0;
        end else begin
            if (busy) begin
                if (prev_idx != 0 && tableIndex == 0) wrapped = 1'b1;
                if (int'(tableIndex) > max_idx) max_idx = int'(tableIndex);
                prev_idx = tableIndex;
            end
            if (i2cStartWrite) begin
                wr_count++;
                if (wr_count == 1) first_wr_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected got reg=%h data=%h, none expected", i2cRegister, i2cData);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({i2cRegister, i2cData} !== exp_e) begin
                        errors++;
                        $display("FAIL write_payload got %h want %h", {i2cRegister, i2cData}, exp_e);
                    end
                end
                pend    = 1'b1;
                pend_rd = 1'b0;
            end else if (i2cStartRead) begin
                pend    = 1'b1;
                pend_rd = 1'b1;
            end else if (pend) begin
                pend    = 1'b0;
                i2cBusy = 1'b1;
                bcnt    = 3;
            end else if (i2cBusy) begin
                bcnt--;
                if (bcnt == 0) begin
                    i2cBusy = 1'b0;
                    if (pend_rd) begin
                        i2cAckError = 1'b0;
                        i2cDataOut  = (rb_bad_left > 0) ? 8'h7F : i2cData;
                        if (rb_bad_left > 0) rb_bad_left--;
                    end else begin
                        i2cAckError = (i2cRegister == nack_reg) && (nack_left > 0);
                        if (i2cAckError) nack_left--;
                    end
                end
            end
        end
    end

    task automatic load_table(input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3);
        tbl[0] = e0; tbl[1] = e1; tbl[2] = e2; tbl[3] = e3;
    endtask

    task automatic do_start();
        @(negedge clock);
        prev_idx = '0; max_idx = 0; wrapped = 1'b0; wr_count = 0;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clock);
            if (!busy) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_timeout busy still 1 after 2000 cycles", name);
        end
    endtask

    task automatic wait_master_busy(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            if (i2cBusy) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_no_transfer master never went busy", name);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, done, error, i2cStartWrite, i2cStartRead} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000", {busy, done, error, i2cStartWrite, i2cStartRead});
        end
        checks++;
        if (i2cAddress !== 7'h21) begin
            errors++;
            $display("FAIL reset_address got %h want 21", i2cAddress);
        end
        checks++;
        if ({tableIndex, failedIndex, i2cRegister, i2cData} !== 20'h0) begin
            errors++;
            $display("FAIL reset_regs got %h want 0", {tableIndex, failedIndex, i2cRegister, i2cData});
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_single_write();
        load_table(16'h1280, 16'hFF00, 16'h0000, 16'h0000);
        nack_left = 0;
        exp_q.push_back(16'h1280);
        do_start();
        wait_end("single");
        checks++;
        if ({done, error, busy} !== 3'b100) begin
            errors++;
            $display("FAIL single_status got done/error/busy=%b want 100", {done, error, busy});
        end
        checks++;
        if (wr_count != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_count got %0d writes (%0d pending) want 1 (0)", wr_count, exp_q.size());
        end
        repeat (3) @(negedge clock);
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL single_sticky got done/busy=%b want 10", {done, busy});
        end
    endtask

    task automatic test_delay();
        load_table(16'hFE02, 16'h1101, 16'hFF00, 16'h0000);
        exp_q.push_back(16'h1101);
        do_start();
        wait_end("delay");
        checks++;
        if ({done, error} !== 2'b10 || wr_count != 1) begin
            errors++;
            $display("FAIL delay_status got done/error=%b writes=%0d want 10 writes=1", {done, error}, wr_count);
        end
        // DECODE of entry 0 is two cycles after the start pulse is taken
        checks++;
        if ((first_wr_cyc - (start_cyc + 2)) < 20 || (first_wr_cyc - (start_cyc + 2)) > 30) begin
            errors++;
            $display("FAIL delay_latency got %0d cycles want 20..30", first_wr_cyc - (start_cyc + 2));
        end
    endtask

    task automatic test_nack_recovery();
        load_table(16'h1001, 16'h2002, 16'hFF00, 16'h0000);
        nack_reg = 8'h20; nack_left = 2;
        exp_q.push_back(16'h1001);
        for (int i = 0; i < 3; i++) exp_q.push_back(16'h2002);
        do_start();
        wait_end("nack_recover");
        checks++;
        if ({done, error} !== 2'b10 || wr_count != 4 || exp_q.size() != 0 || nack_left != 0) begin
            errors++;
            $display("FAIL nack_recover got done/error=%b writes=%0d want 10 writes=4", {done, error}, wr_count);
        end
    endtask

    task automatic test_nack_exhausted();
        load_table(16'h1001, 16'h2002, 16'h3003, 16'hFF00);
        nack_reg = 8'h30; nack_left = 100;
        exp_q.push_back(16'h1001);
        exp_q.push_back(16'h2002);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h3003);
        do_start();
        wait_end("nack_exhaust");
        checks++;
        if ({done, error} !== 2'b01 || failedIndex !== 2'd2) begin
            errors++;
            $display("FAIL nack_exhaust_status got done/error=%b failedIndex=%0d want 01 2", {done, error}, failedIndex);
        end
        checks++;
        if (wr_count != 6 || exp_q.size() != 0 || max_idx != 2) begin
            errors++;
            $display("FAIL nack_exhaust_count got writes=%0d maxidx=%0d want 6 2", wr_count, max_idx);
        end
        nack_left = 0;
        exp_q.delete();
    endtask

    task automatic test_no_end_marker();
        load_table(16'h1001, 16'h2002, 16'h3003, 16'h4004);
        for (int i = 1; i <= 4; i++) exp_q.push_back({4'(i), 4'h0, 8'(i)} | 16'h0000);
        do_start();
        wait_end("no_end");
        checks++;
        if ({done, error} !== 2'b10 || wr_count != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL no_end_status got done/error=%b writes=%0d want 10 writes=4", {done, error}, wr_count);
        end
        checks++;
        if (wrapped || max_idx != 3) begin
            errors++;
            $display("FAIL no_end_index got wrapped=%0d maxidx=%0d want 0 3", wrapped, max_idx);
        end
    endtask

    task automatic test_start_ignored();
        load_table(16'h1001, 16'hFF00, 16'h0000, 16'h0000);
        exp_q.push_back(16'h1001);
        do_start();
        wait_master_busy("start_ignored");
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_end("start_ignored");
        checks++;
        if ({done, error} !== 2'b10 || wr_count != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL start_ignored got done/error=%b writes=%0d want 10 writes=1", {done, error}, wr_count);
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset_mid_transfer();
        load_table(16'h1001, 16'h2002, 16'hFF00, 16'h0000);
        exp_q.push_back(16'h1001);
        do_start();
        wait_master_busy("reset_mid");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({busy, i2cStartWrite, done, error} !== 4'b0) begin
            errors++;
            $display("FAIL reset_mid got busy/wr/done/error=%b want 0000", {busy, i2cStartWrite, done, error});
        end
        reset = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || wr_count != 1) begin
            errors++;
            $display("FAIL reset_mid_idle got busy=%b writes=%0d want 0 1", busy, wr_count);
        end
    endtask

`ifdef I2C_INIT_SEQUENCER_READBACK_EN
    task automatic test_readback();
        load_table(16'h1280, 16'hFF00, 16'h0000, 16'h0000);
        rb_bad_left = 1;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1280);
        do_start();
        wait_end("readback");
        checks++;
        if ({done, error} !== 2'b10 || wr_count != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL readback_retry got done/error=%b writes=%0d want 10 writes=2", {done, error}, wr_count);
        end
    endtask
`endif

    initial begin
        load_table(16'h0, 16'h0, 16'h0, 16'h0);
        test_reset();
        test_single_write();
        test_delay();
        test_nack_recovery();
        test_nack_exhausted();
        test_no_end_marker();
        test_start_ignored();
        test_reset_mid_transfer();
`ifdef I2C_INIT_SEQUENCER_READBACK_EN
        test_readback();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
